// File: rtl/w0rm_peripheral_timer_if.sv
// w0rm_peripheral_timer_if: W0RM peripheral data bus request/response bundle
interface w0rm_peripheral_timer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_valid_i;
  logic                  mem_read_i;
  logic                  mem_write_i;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic                  mem_valid_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  modport master (
    output mem_valid_i, mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
    input  mem_valid_o, mem_data_o
  );
  modport slave (
    input  mem_valid_i, mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
    output mem_valid_o, mem_data_o
  );
endinterface

// File: rtl/w0rm_peripheral_timer.sv
// w0rm_peripheral_timer: prescaled down-counting bus timer with sticky expiry and irq
module w0rm_peripheral_timer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000100
) (
  input  logic                     mem_clk,
  input  logic                     cpu_reset_n,
  w0rm_peripheral_timer_if.slave   bus,
  output logic                     irq_o
);
  logic                  hit, rd, wr_ctrl, wr_count, wr_load, wr_status, tick, expire;
  logic [1:0]            sel;
  logic                  en_q, en_d, auto_q, auto_d, irq_en_q, irq_en_d, exp_q, exp_d;
  logic [7:0]            presc_q, presc_d, pcnt_q, pcnt_d;
  logic [DATA_WIDTH-1:0] count_q, count_d, load_q, load_d, rdata_q, rdata_d, rmux;
  logic                  rvalid_q, rvalid_d;
  assign hit       = bus.mem_valid_i & (bus.mem_read_i | bus.mem_write_i) &
                     (bus.mem_addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign sel       = bus.mem_addr_i[3:2];
  assign rd        = hit & bus.mem_read_i;
  assign wr_ctrl   = hit & bus.mem_write_i & (sel == 2'd0);
  assign wr_count  = hit & bus.mem_write_i & (sel == 2'd1);
  assign wr_load   = hit & bus.mem_write_i & (sel == 2'd2);
  assign wr_status = hit & bus.mem_write_i & (sel == 2'd3);
  assign tick      = en_q & (pcnt_q == presc_q);
  assign expire    = tick & (count_q == '0);
  assign irq_o     = exp_q & irq_en_q;
  assign bus.mem_valid_o = rvalid_q;
  assign bus.mem_data_o  = rdata_q;
  // register read mux, sampled from pre-edge state
  always_comb begin
    rmux = sel == 2'd0 ? DATA_WIDTH'({presc_q, 5'b0, irq_en_q, auto_q, en_q}) :
           sel == 2'd1 ? count_q :
           sel == 2'd2 ? load_q  : DATA_WIDTH'(exp_q);
  end
  // next state: bus writes override counting, expiry overrides status clear
  always_comb begin
    en_d     = wr_ctrl ? bus.mem_data_i[0] : (expire & ~auto_q) ? 1'b0 : en_q;
    auto_d   = wr_ctrl ? bus.mem_data_i[1] : auto_q;
    irq_en_d = wr_ctrl ? bus.mem_data_i[2] : irq_en_q;
    presc_d  = wr_ctrl ? bus.mem_data_i[15:8] : presc_q;
    pcnt_d   = (wr_ctrl | ~en_q | tick) ? 8'd0 : pcnt_q + 8'd1;
    count_d  = wr_count ? bus.mem_data_i :
               ~tick ? count_q :
               (count_q != '0) ? count_q - DATA_WIDTH'(1) :
               auto_q ? load_q : count_q;
    load_d   = wr_load ? bus.mem_data_i : load_q;
    exp_d    = expire | (exp_q & ~(wr_status & bus.mem_data_i[0]));
    rvalid_d = hit;
    rdata_d  = rd ? rmux : '0;
  end
  // state registers with asynchronous reset that also drops any pending response
  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      count_q  <= '0;
      load_q   <= '0;
      exp_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      count_q  <= count_d;
      load_q   <= load_d;
      exp_q    <= exp_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_w0rm_peripheral_timer.sv
// tb_w0rm_peripheral_timer: directed plus random bus traffic against a behavioural timer model
module tb_w0rm_peripheral_timer;
  localparam logic [31:0] B = 32'h80000100;
  logic mem_clk = 1'b0;
  logic cpu_reset_n = 1'b0;
  logic irq_o;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] m_ctrl, m_count, m_load, e_data, last_data;
  logic [7:0]  m_pcnt;
  logic        m_exp, e_valid;
  logic [31:0] seq [6];
  w0rm_peripheral_timer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  w0rm_peripheral_timer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(B)) dut (
    .mem_clk(mem_clk), .cpu_reset_n(cpu_reset_n), .bus(bus), .irq_o(irq_o)
  );
  always #5 mem_clk = ~mem_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic m_reset();
    m_ctrl = 0; m_count = 0; m_load = 0; m_exp = 0; m_pcnt = 0; e_valid = 0; e_data = 0;
  endtask
  function automatic logic [31:0] m_reg(input logic [1:0] s);
    return s == 0 ? m_ctrl : s == 1 ? m_count : s == 2 ? m_load : {31'b0, m_exp};
  endfunction
  task automatic m_step(input logic v, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic hit, tick;
    logic [1:0] s;
    hit = v && (r || w) && ((a & 32'hFFFF_FFF0) == B);
    s = a[3:2];
    e_valid = hit;
    e_data = (hit && r) ? m_reg(s) : 32'h0;
    tick = m_ctrl[0] && (m_pcnt == m_ctrl[15:8]);
    m_pcnt = (m_ctrl[0] && !tick) ? m_pcnt + 8'd1 : 8'd0;
    if (hit && w && s == 3 && d[0]) m_exp = 0;
    if (tick) begin
      if (m_count != 0) m_count = m_count - 1;
      else begin
        m_exp = 1;
        if (m_ctrl[1]) m_count = m_load;
        else m_ctrl[0] = 0;
      end
    end
    if (hit && w) begin
      if (s == 0) begin m_ctrl = d & 32'h0000_FF07; m_pcnt = 0; end
      if (s == 1) m_count = d;
      if (s == 2) m_load = d;
    end
  endtask
  task automatic cycle(input logic v, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge mem_clk);
    bus.mem_valid_i = v; bus.mem_read_i = r; bus.mem_write_i = w; bus.mem_addr_i = a; bus.mem_data_i = d;
    @(posedge mem_clk);
    m_step(v, r, w, a, d);
    #1;
    chk("rsp_valid", {31'b0, bus.mem_valid_o}, {31'b0, e_valid});
    chk("rsp_data", bus.mem_data_o, e_data);
    chk("irq", {31'b0, irq_o}, {31'b0, m_exp & m_ctrl[2]});
    last_data = bus.mem_data_o;
  endtask
  task automatic wrt(input logic [31:0] a, input logic [31:0] d); cycle(1, 0, 1, a, d); endtask
  task automatic rdr(input logic [31:0] a); cycle(1, 1, 0, a, 0); endtask
  task automatic idle(); cycle(0, 0, 0, 0, 0); endtask
  initial begin
    logic v, r, w;
    logic [31:0] a, d;
    bus.mem_valid_i = 0; bus.mem_read_i = 0; bus.mem_write_i = 0; bus.mem_addr_i = 0; bus.mem_data_i = 0;
    m_reset();
    repeat (2) @(posedge mem_clk);
    #1;
    chk("rst_valid", {31'b0, bus.mem_valid_o}, 0);
    chk("rst_irq", {31'b0, irq_o}, 0);
    @(negedge mem_clk);
    cpu_reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      rdr(B + 32'(4 * i));
      chk("rst_read", last_data, 0);
    end
    wrt(B + 8, 4);
    wrt(B, 7);
    wrt(B + 4, 4);
    for (int i = 0; i < 12; i++) begin
      rdr(B + 4);
      if (i < 6) seq[i] = last_data;
    end
    chk("auto_seq0", seq[0], 4);
    chk("auto_seq1", seq[1], 3);
    chk("auto_seq4", seq[4], 0);
    chk("auto_seq5", seq[5], 4);
    wrt(B, 4);
    chk("irq_set", {31'b0, irq_o}, 1);
    wrt(B + 12, 1);
    chk("irq_clr", {31'b0, irq_o}, 0);
    wrt(B + 8, 4);
    wrt(B, 7);
    wrt(B + 4, 0);
    wrt(B + 12, 1);
    rdr(B + 12);
    chk("exp_wins", last_data, 1);
    wrt(B + 4, 9);
    rdr(B + 4);
    chk("count_wins", last_data, 9);
    wrt(B, 0);
    wrt(B + 12, 1);
    wrt(B + 4, 2);
    wrt(B, 32'h301);
    repeat (11) idle();
    rdr(B + 12);
    chk("oneshot_early", last_data, 0);
    rdr(B);
    chk("oneshot_ctrl", last_data, 32'h300);
    rdr(B + 4);
    chk("oneshot_count", last_data, 0);
    rdr(B + 12);
    chk("oneshot_exp", last_data, 1);
    wrt(B + 4, 32'h1234);
    rdr(B + 16);
    chk("dec_above", {31'b0, bus.mem_valid_o}, 0);
    cycle(1, 0, 1, 32'h800000F0, 32'h55);
    chk("dec_below", {31'b0, bus.mem_valid_o}, 0);
    rdr(B + 6);
    chk("dec_unaligned", last_data, 32'h1234);
    rdr(B);
    chk("dec_ctrl_kept", last_data, 32'h300);
    wrt(B + 8, 3);
    wrt(B, 7);
    repeat (4) idle();
    rdr(B + 4);
    #1;
    cpu_reset_n = 0;
    #1;
    m_reset();
    chk("arst_valid", {31'b0, bus.mem_valid_o}, 0);
    chk("arst_data", bus.mem_data_o, 0);
    chk("arst_irq", {31'b0, irq_o}, 0);
    @(posedge mem_clk);
    #1;
    chk("arst_hold", {31'b0, bus.mem_valid_o}, 0);
    @(negedge mem_clk);
    cpu_reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      rdr(B + 32'(4 * i));
      chk("arst_read", last_data, 0);
    end
    for (int i = 0; i < 2000; i++) begin
      v = $urandom_range(0, 3) != 0;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) != 0) ? B + 32'($urandom_range(0, 15)) : $urandom;
      d = a[3:2] == 0 ? ($urandom & 32'hFFFF_03FF) :
          a[3:2] == 3 ? $urandom : 32'($urandom_range(0, 12));
      cycle(v, r, w, a, d);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/w0rm_peripheral_timer.md
# w0rm_peripheral_timer

Memory-mapped down-counting timer that sits as a responder on the W0RM peripheral data bus, beside the GPIO block and core RAM. It decodes single-cycle core requests in its 16-byte window and answers each one exactly one cycle later. The counter is divided by a programmable prescaler and raises a sticky expiry flag and interrupt line on underflow, in one-shot or auto-reload mode.

## Interface
- DATA_WIDTH, 32, bus data width; counter width equals DATA_WIDTH
- ADDR_WIDTH, 32, bus address width
- BASE_ADDR, 32'h80000100, byte base of the 4-word register window; aligned to 16 bytes
- mem_clk  in  1  sole clock; all state on its rising edge
- cpu_reset_n  in  1  reset, asynchronous assert, active-low
- mem_valid_i  in  1  request strobe, one cycle per request
- mem_read_i  in  1  read request qualifier
- mem_write_i  in  1  write request qualifier
- mem_addr_i  in  ADDR_WIDTH  byte address
- mem_data_i  in  DATA_WIDTH  write data
- mem_valid_o  out  1  response strobe
- mem_data_o  out  DATA_WIDTH  read data; 0 whenever mem_valid_o=0
- irq_o  out  1  level interrupt = STATUS.EXP & CTRL.IRQ_EN

## Operation
- Hit = mem_valid_i & (mem_read_i | mem_write_i) & (mem_addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]); mem_addr_i[3:2] selects the register; [1:0] are ignored.
- Registers (offset):
  - 0x0 CTRL: [0] EN, [1] AUTO, [2] IRQ_EN, [15:8] PRESC; other bits read 0.
  - 0x4 COUNT: live counter, read/write.
  - 0x8 LOAD: reload value, read/write.
  - 0xC STATUS: [0] EXP, sticky; writing 1 to bit 0 clears it, writing 0 has no effect.
- Prescaler: 8-bit counter pcnt. While EN=1, tick asserts when pcnt==PRESC, and pcnt then returns to 0; otherwise pcnt increments. pcnt is held at 0 while EN=0 and cleared on any CTRL write.
- On a tick:
  - COUNT≠0: COUNT decrements by 1.
  - COUNT==0: EXP←1. If AUTO=1, COUNT←LOAD. If AUTO=0, COUNT stays 0 and EN←0.
- Period is (LOAD+1)·(PRESC+1) cycles.
- Simultaneous events:
  - A COUNT write in a tick cycle wins over the decrement/reload.
  - A CTRL write in a one-shot expiry cycle wins, so EN takes the written value.
  - EXP set by an expiry wins over a same-cycle clear.
- Reads return register values as they stood before the request edge.
- If mem_read_i and mem_write_i are both set, the write takes effect and the response carries the read data.
- Non-hit requests are ignored entirely: no response and no state change.

## Timing
- Reset (asynchronous, while cpu_reset_n=0): CTRL=0, COUNT=0, LOAD=0, EXP=0, pcnt=0, mem_valid_o=0, mem_data_o=0, irq_o=0.
- Release of reset takes effect on the first rising mem_clk edge after cpu_reset_n=1.
- Response latency is exactly 1 cycle. A hit at edge N gives mem_valid_o=1 for exactly the cycle after edge N.
  - Reads return data in that cycle.
  - Writes return mem_data_o=0.
- Back-to-back hits give back-to-back responses; there is no stall and no backpressure.
- Register writes are visible on reads issued in the next cycle.
- irq_o is registered-equivalent: it rises in the cycle after the expiring tick edge and falls in the cycle after the clearing write.
- A reset asserted mid-count or mid-response aborts immediately. A pending response is dropped.

## Test plan
- Reset then read all four offsets (0x80000100/104/108/10C) -> each gives mem_valid_o=1 one cycle later with data 0; irq_o=0.
- LOAD=4, CTRL=0x0000_0007 (PRESC=0, AUTO, IRQ_EN) -> COUNT sequence 4,3,2,1,0,4 after COUNT=4 is written; EXP and irq_o set every 5 cycles; writing STATUS=1 drops irq_o the next cycle.
- One-shot: COUNT=2, CTRL=0x0000_0301 (PRESC=3) -> expiry after 12 cycles; CTRL reads 0x0000_0300 (EN cleared); COUNT stays 0; EXP=1.
- Simultaneous: a STATUS clear lands on the expiry cycle -> EXP remains 1. A COUNT=9 write lands on a tick -> COUNT reads 9.
- Address decode: a read at 0x80000110 and a write at 0x800000F0 -> no mem_valid_o and registers unchanged. A read at 0x80000106 -> returns COUNT.
- Assert cpu_reset_n low mid-count with a response pending -> outputs and registers read 0 immediately, with no stray mem_valid_o.
